// File: rtl/alu_uart_sequencer.sv
// Sequencer between a UART and an ALU: gathers A, B and opcode bytes, registers them
// onto the ALU inputs, then sends the ALU result back as one byte.
module alu_uart_sequencer #(
  parameter int DBIT    = 8,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_done,
  input  logic [DBIT-1:0] rx_data,
  input  logic            tx_done,
  input  logic [DBIT-1:0] alu_result,
  output logic [DBIT-1:0] alu_a,
  output logic [DBIT-1:0] alu_b,
  output logic [5:0]      alu_opcode,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_data,
  output logic            busy,
  output logic            timeout_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_A, S_B, S_OP, S_EXEC, S_SEND, S_WAIT_TX
  } state_t;

  state_t          r_state;
  logic [DBIT-1:0] r_alu_a;
  logic [DBIT-1:0] r_alu_b;
  logic [5:0]      r_alu_opcode;
  logic [DBIT-1:0] r_tx_data;
  logic            r_tx_start;
  logic            r_busy;
  logic            r_timeout_err;
  logic [CW-1:0]   r_cnt;

  // Expiry only matters while waiting for B or the opcode; a byte in the same cycle wins.
  logic w_expired;
  assign w_expired = (TIMEOUT != 0) && (r_cnt == LIMIT) && !rx_done;

  // NOTE: every state bit and registered output uses <= so all of them update from
  // the same pre-edge values; mixing in = here would make results depend on order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_A;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_opcode  <= '0;
      r_tx_data     <= '0;
      r_tx_start    <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_tx_start    <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_A: begin
          r_cnt <= '0;
          if (rx_done) begin
            r_alu_a <= rx_data;
            r_state <= S_B;
            r_busy  <= 1'b1;
          end
        end
        S_B, S_OP: begin
          if (rx_done) begin
            r_cnt <= '0;
            if (r_state == S_B) begin
              r_alu_b <= rx_data;
              r_state <= S_OP;
            end else begin
              r_alu_opcode <= rx_data[5:0];
              r_state      <= S_EXEC;
            end
          end else if (w_expired) begin
            r_cnt         <= '0;
            r_state       <= S_A;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
          end else if (TIMEOUT != 0) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_EXEC: begin
          // Raise tx_start and tx_data together so they appear in the S_SEND cycle.
          r_tx_data  <= alu_result;
          r_tx_start <= 1'b1;
          r_state    <= S_SEND;
        end
        S_SEND: r_state <= S_WAIT_TX;
        S_WAIT_TX: begin
          if (tx_done) begin
            r_state <= S_A;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_A;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_opcode  = r_alu_opcode;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Bench for alu_uart_sequencer: directed byte transactions, a stub ALU, and a
// scoreboard monitor that checks every tx_start against queued expected bytes.
module tb_alu_uart_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       tx_done;
  logic [7:0] alu_result;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_opcode;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       timeout_err;

  int         n_cmp  = 0;
  int         n_fail = 0;
  int         n_to   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  alu_uart_sequencer #(.DBIT(8), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .tx_done     (tx_done),
    .alu_result  (alu_result),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // Stub ALU using MIPS funct codes; unknown codes give 0.
  always_comb begin
    alu_result = 8'h00;
    case (alu_opcode)
      6'h20: alu_result = alu_a + alu_b;
      6'h22: alu_result = alu_a - alu_b;
      6'h02: alu_result = alu_a >> alu_b;
      6'h03: alu_result = $signed(alu_a) >>> alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every tx_start must match the oldest queued expected byte.
  always @(negedge clk) begin
    if (timeout_err) n_to++;
    if (tx_start) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tx_start", 32'(tx_data), 32'hFFFF_FFFF);
      end else begin
        check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input logic [7:0] exp, input bit junk);
    int lat;
    logic [7:0] op_m;
    op_m = op & 8'h3F;
    send_byte(a);
    @(negedge clk);
    check("busy_rise", 32'(busy), 32'd1);
    send_byte(b);
    send_byte(op);
    exp_q.push_back(exp);
    check("alu_opcode", 32'(alu_opcode), 32'(op_m[5:0]));
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (tx_start) begin
        lat = i;
        break;
      end
    end
    check("tx_start_latency", 32'(lat), 32'd2);
    @(posedge clk); #1;
    if (junk) begin
      send_byte(8'hAA);
      send_byte(8'h55);
    end
    @(negedge clk);
    check("tx_data_hold", 32'(tx_data), 32'(exp));
    check("busy_wait_tx", 32'(busy), 32'd1);
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    @(negedge clk);
    check("busy_fall", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    check({tag, "_opcode"}, 32'(alu_opcode), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int to_before;
    reset   = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // ADD, SUB, SRA, SRL
    run_txn(8'h05, 8'h03, 8'h20, 8'h08, 1'b0);
    run_txn(8'h03, 8'h05, 8'h22, 8'hFE, 1'b0);
    run_txn(8'h80, 8'h01, 8'h03, 8'hC0, 1'b0);
    run_txn(8'h80, 8'h01, 8'h02, 8'h40, 1'b0);

    // Opcode masking (0xE0 -> 0x20) and unknown opcode default
    run_txn(8'h10, 8'h20, 8'hE0, 8'h30, 1'b0);
    run_txn(8'h12, 8'h34, 8'h3F, 8'h00, 1'b0);

    // Timeout after A with 16 idle cycles in S_B
    @(posedge clk); #1;
    to_before = n_to;
    send_byte(8'h07);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("pre_timeout_err", 32'(timeout_err), 32'd0);
    check("pre_timeout_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("timeout_err_pulse", 32'(timeout_err), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("timeout_err_one_cycle", 32'(timeout_err), 32'd0);
    check("timeout_count", 32'(n_to - to_before), 32'd1);
    run_txn(8'h01, 8'h01, 8'h20, 8'h02, 1'b0);

    // Byte arriving on the expiry cycle wins over the timeout
    @(posedge clk); #1;
    to_before = n_to;
    send_byte(8'h09);
    repeat (15) begin
      @(posedge clk); #1;
    end
    send_byte(8'h04);
    @(negedge clk);
    check("expiry_byte_no_err", 32'(timeout_err), 32'd0);
    check("expiry_byte_busy", 32'(busy), 32'd1);
    check("expiry_byte_alu_b", 32'(alu_b), 32'h04);
    exp_q.push_back(8'h05);
    send_byte(8'h22);
    repeat (3) @(negedge clk);
    check("expiry_no_timeout", 32'(n_to - to_before), 32'd0);
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    @(negedge clk);
    check("expiry_busy_fall", 32'(busy), 32'd0);

    // rx_done pulses during S_WAIT_TX are dropped
    run_txn(8'h20, 8'h08, 8'h22, 8'h18, 1'b1);
    run_txn(8'h0F, 8'h01, 8'h20, 8'h10, 1'b0);

    // Reset after byte B
    @(posedge clk); #1;
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    run_txn(8'h06, 8'h07, 8'h20, 8'h0D, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
